riscv_zero_fetch: RTL



---
 rtl/riscv_zero_pkg.sv | 15 +
 rtl/riscv_zero_fetch_fifo.sv | 62 ++++++
 rtl/riscv_zero_fetch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_zero_pkg.sv
// Shared definitions for the riscv_zero core: datapath width, canonical NOP,
// PC increment and the fetch-buffer entry layout.
package riscv_zero_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_zero_fetch_fifo.sv
// Small synchronous FIFO with push/pop/flush. Serves both as the fetch output
// buffer and as the in-flight PC tag queue. Flush (and reset) take priority
// over a same-cycle push or pop. Push on a full FIFO is accepted only when a
// pop happens in the same cycle.
module riscv_zero_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop  = i_pop && !i_flush && (r_count != '0);
  assign w_push = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/riscv_zero_fetch.sv
// Instruction fetch stage of riscv_zero. Owns the PC, issues in-order word
// requests to instruction memory under a credit limit of FIFO_DEPTH words
// (in flight + buffered), tags each returning word with its PC and hands
// {pc, inst} to decode over valid/ready. Redirects flush the buffer and
// discard responses still in flight.
// Optional: define RISCV_ZERO_FETCH_MISALIGN_TRAP_EN to add fetch_misaligned,
// which latches on a redirect to a non-word-aligned target and halts fetch
// until the next aligned redirect.
module riscv_zero_fetch
  import riscv_zero_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] pc_out
`ifdef RISCV_ZERO_FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]              r_pc;
  logic [XLEN-1:0]              r_last_pc;
  logic [CW-1:0]                r_drop_cnt;
  logic [CW-1:0]                w_tag_count;
  logic [CW-1:0]                w_out_count;
  logic [CW-1:0]                w_outstanding;
  logic [XLEN-1:0]              w_tag_head;
  logic [XLEN-1:0]              w_target;
  logic [$bits(fetch_entry_t)-1:0] w_out_head_raw;
  fetch_entry_t                 w_out_head;
  fetch_entry_t                 w_push_entry;
  logic                         w_out_empty;
  logic                         w_halt;
  logic                         w_credit;
  logic                         w_req_fire;
  logic                         w_rsp_drop;
  logic                         w_rsp_keep;
  logic                         w_pop;

`ifdef RISCV_ZERO_FETCH_MISALIGN_TRAP_EN
  logic r_misaligned;
  assign w_halt           = r_misaligned;
  assign fetch_misaligned = r_misaligned;
`else
  // Target low bits are ignored when the trap is not built in.
  logic w_unused_redirect_lsb;
  assign w_unused_redirect_lsb = ^redirect_pc[1:0];
  assign w_halt = 1'b0;
`endif

  assign w_target = {redirect_pc[XLEN-1:2], 2'b00};

  // Every in-flight request either owns a tag or is counted for discard.
  assign w_outstanding = w_tag_count + r_drop_cnt;

  assign w_out_empty = (w_out_count == '0);
  assign if_valid    = !w_out_empty;
  assign w_out_head  = fetch_entry_t'(w_out_head_raw);
  assign inst_data   = w_out_empty ? NOP_INST : w_out_head.inst;
  assign pc_out      = w_out_empty ? r_last_pc : w_out_head.pc;

  // A redirect flushes the buffer, so it suppresses the pop it coincides with.
  assign w_pop = if_valid && if_ready && !redirect_valid;

  // The entry leaving this cycle frees its slot, which is what lets a 1-cycle
  // memory sustain one instruction per cycle with only two credits.
  assign w_credit = (32'(w_outstanding) + 32'(w_out_count)) < (FIFO_DEPTH + 32'(w_pop));

  assign imem_req_valid = !reset && !redirect_valid && !w_halt && w_credit;
  assign imem_addr      = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_drop = imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0));
  assign w_rsp_keep = imem_rsp_valid && !w_rsp_drop;

  assign w_push_entry = '{pc: w_tag_head, inst: imem_rsp_data};

  riscv_zero_fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_req_fire),
    .i_data  (r_pc),
    .i_pop   (w_rsp_keep),
    .i_flush (redirect_valid),
    .o_head  (w_tag_head),
    .o_count (w_tag_count)
  );

  riscv_zero_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rsp_keep),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_out_head_raw),
    .o_count (w_out_count)
  );

  // PC advance, redirect capture and stale-response discard accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_last_pc  <= RESET_PC;
      r_drop_cnt <= '0;
`ifdef RISCV_ZERO_FETCH_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      if (redirect_valid) begin
        r_pc       <= w_target;
        // No request is issued this cycle, so only a response can change it.
        r_drop_cnt <= w_outstanding - CW'(imem_rsp_valid);
`ifdef RISCV_ZERO_FETCH_MISALIGN_TRAP_EN
        r_misaligned <= |redirect_pc[1:0];
`endif
      end else begin
        if (w_req_fire) r_pc <= r_pc + PC_STEP;
        if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      if (w_pop) r_last_pc <= w_out_head.pc;
    end
  end

endmodule
